monitor_host: RTL and testbench

- Initiator side of the serial monitor protocol: a UART byte stream of addr_hi, addr_lo and a command byte {op[1:0], len[5:0]}, optionally followed by payload.
- Drives a uart instance so one FPGA can load, dump or start a program on another board running the monitor. Also serves as a self-test driver.
- Runs in lock-step with the remote monitor: every byte it sends must come back as an echo before the next byte goes out.

---
 rtl/monitor_host.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_monitor_host.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/monitor_host.sv
// monitor_host: initiator side of the serial monitor protocol.
// Sends addr_hi, addr_lo and a command byte {op, len} through a uart, waits
// for each byte to be echoed back before sending the next one, then streams
// load bytes out, collects dump bytes, or finishes straight away for EXEC.
// Optional build macro: MONITOR_HOST_ECHO_CHECK_EN compares every echo with
// the byte that was sent. Without it, echoes are awaited but not compared.
module monitor_host #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] addr,
  input  logic [5:0]  len,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic        ld_req,
  input  logic [7:0]  ld_byte,
  output logic [7:0]  dp_byte,
  output logic        dp_valid,
  output logic [7:0]  tx_byte,
  output logic        transmit,
  input  logic        is_transmitting,
  input  logic        received,
  input  logic [7:0]  rx_byte
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_DUMP = 2'b10;
  localparam logic [1:0] OP_EXEC = 2'b11;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ECHO = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_OP   = 2'b11;

  typedef enum logic [3:0] {
    IDLE,
    HDR_TX,
    HDR_ECHO,
    LD_FETCH,
    LD_WAIT,
    LD_TX,
    LD_ECHO,
    PAD_TX,
    PAD_GUARD,
    PAD_WAIT,
    DP_RX,
    DONE
  } state_t;

  state_t          state, state_next;
  logic [1:0]      hdr_idx, hdr_idx_next;
  logic [1:0]      cur_op, cur_op_next;
  logic [15:0]     cur_addr, cur_addr_next;
  logic [7:0]      cmd, cmd_next;
  logic [5:0]      remaining, remaining_next;
  logic [7:0]      ld_data, ld_data_next;
  logic [TW-1:0]   tmo_cnt, tmo_cnt_next;

  logic            busy_next, done_next, error_next;
  logic [1:0]      err_code_next;
  logic            ld_req_next;
  logic [7:0]      dp_byte_next;
  logic            dp_valid_next;
  logic [7:0]      tx_byte_next;
  logic            transmit_next;

  logic            abort;
  logic [1:0]      abort_code;
  logic            tmo_expired;
  logic            echo_bad;
  logic [7:0]      hdr_byte;

`ifdef MONITOR_HOST_ECHO_CHECK_EN
  // tx_byte is held after each send, so it is the reference for the echo.
  assign echo_bad = (rx_byte != tx_byte);
`else
  assign echo_bad = 1'b0;
`endif

  // The wait for an rx byte gives up once the counter has run its full span.
  assign tmo_expired = (tmo_cnt == TMO_LAST);

  // Header byte selected by the header index: addr_hi, addr_lo, cmd.
  always_comb begin
    unique case (hdr_idx)
      2'd0:    hdr_byte = cur_addr[15:8];
      2'd1:    hdr_byte = cur_addr[7:0];
      default: hdr_byte = cmd;
    endcase
  end

  // Next-state and next-output logic for the protocol sequencer.
  always_comb begin
    // NOTE: every *_next gets a default first so no latch is inferred; this
    // block uses blocking assignments because it is purely combinational.
    state_next     = state;
    hdr_idx_next   = hdr_idx;
    cur_op_next    = cur_op;
    cur_addr_next  = cur_addr;
    cmd_next       = cmd;
    remaining_next = remaining;
    ld_data_next   = ld_data;
    tmo_cnt_next   = tmo_cnt;
    busy_next      = busy;
    done_next      = 1'b0;
    error_next     = error;
    err_code_next  = err_code;
    ld_req_next    = 1'b0;
    dp_byte_next   = dp_byte;
    dp_valid_next  = 1'b0;
    tx_byte_next   = tx_byte;
    transmit_next  = 1'b0;
    abort          = 1'b0;
    abort_code     = ERR_NONE;

    unique case (state)
      IDLE: begin
        if (start) begin
          if (op == 2'b00) begin
            done_next     = 1'b1;
            error_next    = 1'b1;
            err_code_next = ERR_OP;
          end else begin
            busy_next      = 1'b1;
            error_next     = 1'b0;
            err_code_next  = ERR_NONE;
            cur_op_next    = op;
            cur_addr_next  = addr;
            cmd_next       = {op, (op == OP_EXEC) ? 6'd0 : len};
            remaining_next = (op == OP_EXEC) ? 6'd0 : len;
            hdr_idx_next   = 2'd0;
            state_next     = HDR_TX;
          end
        end
      end

      HDR_TX: begin
        if (!is_transmitting) begin
          tx_byte_next  = hdr_byte;
          transmit_next = 1'b1;
          tmo_cnt_next  = '0;
          state_next    = HDR_ECHO;
        end
      end

      HDR_ECHO: begin
        if (received) begin
          tmo_cnt_next = '0;
          if (echo_bad) begin
            abort      = 1'b1;
            abort_code = ERR_ECHO;
          end else if (hdr_idx != 2'd2) begin
            hdr_idx_next = hdr_idx + 2'd1;
            state_next   = HDR_TX;
          end else begin
            unique case (cur_op)
              OP_EXEC: state_next = DONE;
              OP_LOAD: begin
                if (remaining == 6'd0) begin
                  state_next = PAD_TX;
                end else begin
                  ld_req_next = 1'b1;
                  state_next  = LD_FETCH;
                end
              end
              default: state_next = (remaining == 6'd0) ? DONE : DP_RX;
            endcase
          end
        end else if (tmo_expired) begin
          abort      = 1'b1;
          abort_code = ERR_TMO;
        end else begin
          tmo_cnt_next = tmo_cnt + 1'b1;
        end
      end

      // ld_req is high during this state; the source answers one cycle later.
      LD_FETCH: state_next = LD_WAIT;

      LD_WAIT: begin
        ld_data_next = ld_byte;
        state_next   = LD_TX;
      end

      LD_TX: begin
        if (!is_transmitting) begin
          tx_byte_next  = ld_data;
          transmit_next = 1'b1;
          tmo_cnt_next  = '0;
          state_next    = LD_ECHO;
        end
      end

      LD_ECHO: begin
        if (received) begin
          tmo_cnt_next = '0;
          if (echo_bad) begin
            abort      = 1'b1;
            abort_code = ERR_ECHO;
          end else begin
            remaining_next = remaining - 6'd1;
            if (remaining == 6'd1) begin
              state_next = DONE;
            end else begin
              ld_req_next = 1'b1;
              state_next  = LD_FETCH;
            end
          end
        end else if (tmo_expired) begin
          abort      = 1'b1;
          abort_code = ERR_TMO;
        end else begin
          tmo_cnt_next = tmo_cnt + 1'b1;
        end
      end

      // Zero-length load: the remote monitor needs one filler byte to leave
      // its load loop, and it does not echo that byte.
      PAD_TX: begin
        if (!is_transmitting) begin
          tx_byte_next  = 8'h00;
          transmit_next = 1'b1;
          tmo_cnt_next  = '0;
          state_next    = PAD_GUARD;
        end
      end

      // The uart may raise is_transmitting a cycle late, so skip one cycle.
      PAD_GUARD: state_next = PAD_WAIT;

      PAD_WAIT: begin
        if (!is_transmitting) begin
          state_next = DONE;
        end
      end

      DP_RX: begin
        if (received) begin
          tmo_cnt_next   = '0;
          dp_byte_next   = rx_byte;
          dp_valid_next  = 1'b1;
          remaining_next = remaining - 6'd1;
          if (remaining == 6'd1) begin
            state_next = DONE;
          end
        end else if (tmo_expired) begin
          abort      = 1'b1;
          abort_code = ERR_TMO;
        end else begin
          tmo_cnt_next = tmo_cnt + 1'b1;
        end
      end

      DONE: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase

    // Any failure ends the operation at once; nothing more is sent.
    if (abort) begin
      state_next    = IDLE;
      done_next     = 1'b1;
      busy_next     = 1'b0;
      error_next    = 1'b1;
      err_code_next = abort_code;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every register samples the
    // pre-edge value of every other register.
    if (rst) begin
      state     <= IDLE;
      hdr_idx   <= 2'd0;
      cur_op    <= 2'b00;
      cur_addr  <= 16'h0000;
      cmd       <= 8'h00;
      remaining <= 6'd0;
      ld_data   <= 8'h00;
      tmo_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= ERR_NONE;
      ld_req    <= 1'b0;
      dp_byte   <= 8'h00;
      dp_valid  <= 1'b0;
      tx_byte   <= 8'h00;
      transmit  <= 1'b0;
    end else begin
      state     <= state_next;
      hdr_idx   <= hdr_idx_next;
      cur_op    <= cur_op_next;
      cur_addr  <= cur_addr_next;
      cmd       <= cmd_next;
      remaining <= remaining_next;
      ld_data   <= ld_data_next;
      tmo_cnt   <= tmo_cnt_next;
      busy      <= busy_next;
      done      <= done_next;
      error     <= error_next;
      err_code  <= err_code_next;
      ld_req    <= ld_req_next;
      dp_byte   <= dp_byte_next;
      dp_valid  <= dp_valid_next;
      tx_byte   <= tx_byte_next;
      transmit  <= transmit_next;
    end
  end

endmodule

// File: tb/tb_monitor_host.sv
// Directed bench for monitor_host: a behavioural uart/remote-monitor model
// echoes sent bytes and can inject dump data, a sync-memory model answers
// ld_req, and a monitor logs transmits, load requests, dump bytes and done.
module tb_monitor_host;

  localparam int T = 50;

  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_DUMP = 2'b10;
  localparam logic [1:0] OP_EXEC = 2'b11;

  typedef logic [7:0] bq_t[$];

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] addr;
  logic [5:0]  len;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic        ld_req;
  logic [7:0]  ld_byte;
  logic [7:0]  dp_byte;
  logic        dp_valid;
  logic [7:0]  tx_byte;
  logic        transmit;
  logic        is_transmitting;
  logic        received;
  logic [7:0]  rx_byte;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bq_t tx_q;
  bq_t dp_q;
  bq_t ld_mem;
  bq_t dump_q;
  int  ld_ptr = 0;
  int  ld_cnt = 0;
  int  done_cnt = 0;
  int  echo_limit = 99;
  int  corrupt_idx = -1;
  int  rx_cyc = 0;

  monitor_host #(.TIMEOUT_CYCLES(T)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .op              (op),
    .addr            (addr),
    .len             (len),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .err_code        (err_code),
    .ld_req          (ld_req),
    .ld_byte         (ld_byte),
    .dp_byte         (dp_byte),
    .dp_valid        (dp_valid),
    .tx_byte         (tx_byte),
    .transmit        (transmit),
    .is_transmitting (is_transmitting),
    .received        (received),
    .rx_byte         (rx_byte)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_tx(input string tag, input bq_t exp_q);
    check({tag, "_count"}, tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < tx_q.size()) check($sformatf("%s[%0d]", tag, i), tx_q[i], exp_q[i]);
    end
  endtask

  task automatic clear_logs();
    tick();
    tx_q.delete();
    dp_q.delete();
    ld_cnt = 0;
    done_cnt = 0;
    ld_ptr = 0;
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  // Pulse start for one cycle, then wait (bounded) for done.
  task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [5:0] l,
                        output int done_at);
    op = o;
    addr = a;
    len = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check($sformatf("busy_after_start_op%0d", o), busy, (o != 2'b00));
    done_at = -1;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        done_at = cyc;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", done_at >= 0, 1);
  endtask

  // Uart plus remote monitor: busy for 4 cycles per byte, then echo.
  initial begin : uart_model
    int idx;
    logic [7:0] sent;
    is_transmitting = 1'b0;
    received = 1'b0;
    rx_byte = 8'h00;
    forever begin
      tick();
      if (transmit) begin
        idx = tx_q.size();
        sent = tx_byte;
        is_transmitting = 1'b1;
        repeat (4) tick();
        is_transmitting = 1'b0;
        tick();
        if (idx < echo_limit) begin
          rx_byte = (idx == corrupt_idx) ? 8'h00 : sent;
          received = 1'b1;
          rx_cyc = cyc;
          tick();
          received = 1'b0;
          if (idx == 2) begin
            foreach (dump_q[i]) begin
              repeat (3) tick();
              rx_byte = dump_q[i];
              received = 1'b1;
              tick();
              received = 1'b0;
            end
          end
        end
      end
    end
  end

  // Synchronous memory: data appears one cycle after ld_req, junk otherwise.
  initial begin : mem_model
    ld_byte = 8'hEE;
    forever begin
      @(negedge clk);
      if (ld_req) begin
        tick();
        ld_byte = (ld_ptr < ld_mem.size()) ? ld_mem[ld_ptr] : 8'hEE;
        ld_ptr++;
        tick();
        ld_byte = 8'hEE;
      end
    end
  end

  // Event logger.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (transmit) tx_q.push_back(tx_byte);
      if (ld_req) ld_cnt++;
      if (dp_valid) dp_q.push_back(dp_byte);
      if (done) done_cnt++;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int t_done;
    int lat;
    int n;
    bq_t exp_q;

    // Reset with start held high: reset must win.
    rst = 1'b1;
    start = 1'b1;
    op = OP_LOAD;
    addr = 16'h1234;
    len = 6'd3;
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_err_code", err_code, 0);
    check("rst_transmit", transmit, 0);
    check("rst_ld_req", ld_req, 0);
    check("rst_dp_valid", dp_valid, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_dp_byte", dp_byte, 0);
    tick();
    rst = 1'b0;
    start = 1'b0;
    settle();
    check("rst_start_no_tx", tx_q.size(), 0);

    // LOAD 0x0100, 2 bytes.
    clear_logs();
    ld_mem = {8'hA5, 8'h5A};
    run_op(OP_LOAD, 16'h0100, 6'd2, t_done);
    settle();
    exp_q = {8'h01, 8'h00, 8'h42, 8'hA5, 8'h5A};
    check_tx("load2_tx", exp_q);
    check("load2_ld_req", ld_cnt, 2);
    check("load2_done", done_cnt, 1);
    check("load2_error", error, 0);
    check("load2_busy", busy, 0);

    // DUMP 0x0010, 3 bytes.
    clear_logs();
    dump_q = {8'h11, 8'h22, 8'h33};
    run_op(OP_DUMP, 16'h0010, 6'd3, t_done);
    settle();
    dump_q.delete();
    exp_q = {8'h00, 8'h10, 8'h83};
    check_tx("dump3_tx", exp_q);
    check("dump3_dp_count", dp_q.size(), 3);
    if (dp_q.size() == 3) begin
      check("dump3_dp0", dp_q[0], 8'h11);
      check("dump3_dp1", dp_q[1], 8'h22);
      check("dump3_dp2", dp_q[2], 8'h33);
    end
    check("dump3_done", done_cnt, 1);
    check("dump3_error", error, 0);

    // EXEC with len forced to zero.
    clear_logs();
    run_op(OP_EXEC, 16'h0000, 6'd5, t_done);
    settle();
    exp_q = {8'h00, 8'h00, 8'hC0};
    check_tx("exec_tx", exp_q);
    check("exec_done", done_cnt, 1);
    check("exec_ld_req", ld_cnt, 0);

    // Bad op 00.
    clear_logs();
    run_op(2'b00, 16'h1234, 6'd4, t_done);
    settle();
    check("badop_error", error, 1);
    check("badop_err_code", err_code, 2'b11);
    check("badop_done", done_cnt, 1);
    check("badop_no_tx", tx_q.size(), 0);

    // LOAD len 0: pad byte, no pad echo.
    clear_logs();
    echo_limit = 3;
    run_op(OP_LOAD, 16'h0020, 6'd0, t_done);
    settle();
    echo_limit = 99;
    exp_q = {8'h00, 8'h20, 8'h40, 8'h00};
    check_tx("load0_tx", exp_q);
    check("load0_ld_req", ld_cnt, 0);
    check("load0_done", done_cnt, 1);
    check("load0_error_cleared", error, 0);

    // LOAD len 1 with a corrupted echo of the data byte.
    clear_logs();
    ld_mem = {8'h3C};
    corrupt_idx = 3;
    run_op(OP_LOAD, 16'h0100, 6'd1, t_done);
    settle();
    corrupt_idx = -1;
    exp_q = {8'h01, 8'h00, 8'h41, 8'h3C};
    check_tx("mism_tx", exp_q);
    check("mism_done", done_cnt, 1);
`ifdef MONITOR_HOST_ECHO_CHECK_EN
    check("mism_error", error, 1);
    check("mism_err_code", err_code, 2'b01);
`else
    check("mism_error", error, 0);
    check("mism_err_code", err_code, 2'b00);
`endif

    // DUMP len 1, remote silent after the header: timeout.
    clear_logs();
    echo_limit = 3;
    run_op(OP_DUMP, 16'h0040, 6'd1, t_done);
    lat = t_done - (rx_cyc + 1);
    settle();
    echo_limit = 99;
    exp_q = {8'h00, 8'h40, 8'h81};
    check_tx("tmo_tx", exp_q);
    check("tmo_latency_in_window", (lat >= T - 1) && (lat <= T + 1), 1);
    check("tmo_error", error, 1);
    check("tmo_err_code", err_code, 2'b10);
    check("tmo_done", done_cnt, 1);
    check("tmo_no_dp", dp_q.size(), 0);

    // Reset in the middle of a LOAD header.
    clear_logs();
    op = OP_LOAD;
    addr = 16'h0200;
    len = 6'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && n < 2; i++) begin
      @(negedge clk);
      if (transmit) n++;
    end
    check("midrst_second_tx_seen", n, 2);
    rst = 1'b1;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_transmit", transmit, 0);
    rst = 1'b0;
    repeat (20) tick();
    check("midrst_no_more_tx", tx_q.size(), 2);
    check("midrst_no_done", done_cnt, 0);

    // Recovery after reset.
    clear_logs();
    run_op(OP_EXEC, 16'hBEEF, 6'd7, t_done);
    settle();
    exp_q = {8'hBE, 8'hEF, 8'hC0};
    check_tx("recover_tx", exp_q);
    check("recover_done", done_cnt, 1);
    check("recover_error", error, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
